// File: rtl/imem_loader_if.sv
// imem_loader_if: byte-stream input and instruction-memory write port of the
// boot loader, bundled so the source and the memory can be bound as one unit.
//
// Handshake: a byte on in_data is transferred on a rising CLK edge where
// in_valid and in_ready are both high. in_ready depends only on loader state,
// never on in_valid. A source that raises in_valid must hold in_valid and
// in_data stable until that transfer edge.
// Write port: mem_we is a one-cycle strobe. mem_addr/mem_wdata are meaningful
// only while mem_we is high.
`timescale 1ns/1ps
interface imem_loader_if #(
  parameter int ADDR_W = 8
);
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;

  // Byte source and memory sink side (testbench / boot ROM + imem)
  modport master (
    output in_valid, in_data,
    input  in_ready, mem_we, mem_addr, mem_wdata
  );

  // Loader side
  modport slave (
    input  in_valid, in_data,
    output in_ready, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/imem_loader.sv
// imem_loader: boot-time program loader. Receives a header byte N, then 4*N
// payload bytes (big-endian words), and writes each word into the byte-
// addressed instruction memory starting at address 0. Holds the CPU in reset
// (cpu_rst_n low) until a complete image has been written.
//
// Optional feature: define LOADER_CHECKSUM_EN to require a trailing byte equal
// to the 8-bit sum of the payload bytes; a mismatch ends in ERR.
`timescale 1ns/1ps
module imem_loader #(
  parameter int ADDR_W = 8
) (
  input  logic       CLK,
  input  logic       Reset_n,
  input  logic       start,
  imem_loader_if.slave bus,
  output logic       cpu_rst_n,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [7:0] word_cnt,
  output logic [2:0] dbg_state
);

  // Largest legal word count: 4*N may equal but not exceed 2^ADDR_W bytes.
  localparam logic [31:0] CAP_WORDS = 32'd1 << (ADDR_W - 2);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_HDR   = 3'd1,
    S_DATA  = 3'd2,
    S_WRITE = 3'd3,
`ifdef LOADER_CHECKSUM_EN
    S_CSUM  = 3'd4,
`endif
    S_DONE  = 3'd5,
    S_ERR   = 3'd6
  } state_t;

  // State entered once the last word is written (or on an N=0 header).
`ifdef LOADER_CHECKSUM_EN
  localparam state_t S_TAIL = S_CSUM;
`else
  localparam state_t S_TAIL = S_DONE;
`endif

  // Status outputs are registered together with the state so that each one
  // is a clean flop output that always agrees with the state register.
  typedef struct packed {
    logic in_ready;
    logic busy;
    logic done;
    logic err;
    logic cpu_rst_n;
  } flags_t;

  function automatic flags_t flags_of(input state_t s);
    flags_t f;
    f = '0;
    case (s)
      S_HDR, S_DATA: begin
        f.in_ready = 1'b1;
        f.busy     = 1'b1;
      end
      S_WRITE: f.busy = 1'b1;
`ifdef LOADER_CHECKSUM_EN
      S_CSUM: begin
        f.in_ready = 1'b1;
        f.busy     = 1'b1;
      end
`endif
      S_DONE: begin
        f.done      = 1'b1;
        f.cpu_rst_n = 1'b1;
      end
      S_ERR:   f.err = 1'b1;
      default: f = '0;
    endcase
    return f;
  endfunction

  state_t            state;
  flags_t            flg;
  logic [7:0]        n_q;       // latched word count of the current image
  logic [1:0]        byte_idx;  // payload byte position within the word
  logic [23:0]       word_q;    // first three bytes of the word being built
  logic [ADDR_W-1:0] addr_q;    // byte address of the next word to write
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]        csum_q;    // running mod-256 sum of payload bytes
`endif

  logic accept;
  logic too_big;

  assign accept  = bus.in_valid && flg.in_ready;
  assign too_big = {24'd0, bus.in_data} > CAP_WORDS;

  assign bus.in_ready = flg.in_ready;
  assign busy         = flg.busy;
  assign done         = flg.done;
  assign err          = flg.err;
  assign cpu_rst_n    = flg.cpu_rst_n;
  assign dbg_state    = state;

  // Loader FSM: header decode, word assembly, memory write and final check.
  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      state         <= S_IDLE;
      flg           <= '0;
      n_q           <= '0;
      byte_idx      <= '0;
      word_q        <= '0;
      addr_q        <= '0;
      word_cnt      <= '0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
`ifdef LOADER_CHECKSUM_EN
      csum_q        <= '0;
`endif
    end else begin
      case (state)
        // Idle and both terminal states restart the same way; cpu_rst_n
        // drops on the edge that takes start.
        S_IDLE, S_DONE, S_ERR: begin
          if (start) begin
            state    <= S_HDR;
            flg      <= flags_of(S_HDR);
            word_cnt <= '0;
            byte_idx <= '0;
            addr_q   <= '0;
`ifdef LOADER_CHECKSUM_EN
            csum_q   <= '0;
`endif
          end
        end

        S_HDR: begin
          if (accept) begin
            if (too_big) begin
              state <= S_ERR;
              flg   <= flags_of(S_ERR);
            end else if (bus.in_data == 8'd0) begin
              state <= S_TAIL;
              flg   <= flags_of(S_TAIL);
            end else begin
              n_q   <= bus.in_data;
              state <= S_DATA;
              flg   <= flags_of(S_DATA);
            end
          end
        end

        // Shift bytes in MSB first; the fourth byte launches the write.
        S_DATA: begin
          if (accept) begin
            word_q   <= {word_q[15:0], bus.in_data};
            byte_idx <= byte_idx + 2'd1;
`ifdef LOADER_CHECKSUM_EN
            csum_q   <= csum_q + bus.in_data;
`endif
            if (byte_idx == 2'd3) begin
              state         <= S_WRITE;
              flg           <= flags_of(S_WRITE);
              bus.mem_we    <= 1'b1;
              bus.mem_addr  <= addr_q;
              bus.mem_wdata <= {word_q, bus.in_data};
            end
          end
        end

        // mem_we was raised on entry, so it is high for exactly this cycle.
        S_WRITE: begin
          bus.mem_we <= 1'b0;
          word_cnt   <= word_cnt + 8'd1;
          addr_q     <= addr_q + ADDR_W'(4);
          if (word_cnt + 8'd1 == n_q) begin
            state <= S_TAIL;
            flg   <= flags_of(S_TAIL);
          end else begin
            state <= S_DATA;
            flg   <= flags_of(S_DATA);
          end
        end

`ifdef LOADER_CHECKSUM_EN
        S_CSUM: begin
          if (accept) begin
            if (bus.in_data == csum_q) begin
              state <= S_DONE;
              flg   <= flags_of(S_DONE);
            end else begin
              state <= S_ERR;
              flg   <= flags_of(S_ERR);
            end
          end
        end
`endif

        default: begin
          state      <= S_IDLE;
          flg        <= flags_of(S_IDLE);
          bus.mem_we <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed and randomized loads of imem_loader checked against
// a stream-level reference model (expected writes, final status, latency).
`timescale 1ns/1ps
module tb_imem_loader;
  localparam int ADDR_W    = 8;
  localparam int CAP_WORDS = 2 ** (ADDR_W - 2);
  localparam int W         = ADDR_W + 32;
`ifdef LOADER_CHECKSUM_EN
  localparam int CS = 1;
`else
  localparam int CS = 0;
`endif

  logic       CLK = 1'b0;
  logic       Reset_n = 1'b0;
  logic       start = 1'b0;
  logic       cpu_rst_n, busy, done, err;
  logic [7:0] word_cnt;
  logic [2:0] dbg_state;

  imem_loader_if #(.ADDR_W(ADDR_W)) bus ();

  imem_loader #(.ADDR_W(ADDR_W)) dut (
    .CLK       (CLK),
    .Reset_n   (Reset_n),
    .start     (start),
    .bus       (bus),
    .cpu_rst_n (cpu_rst_n),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .word_cnt  (word_cnt),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset / cycle count ----------------
  always #5 CLK = ~CLK;

  int unsigned cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0]   stim_q[$];
  logic [W-1:0] exp_q[$];
  logic [W-1:0] obs_q[$];
  logic         exp_done, exp_err;
  int           exp_wcnt, exp_lat;
  bit           cs_good;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Write monitor: every cycle with mem_we high is one recorded write.
  always @(negedge CLK) begin
    if (bus.mem_we) obs_q.push_back({bus.mem_addr, bus.mem_wdata});
  end

  // ---------------- reference model ----------------
  // From the byte stream alone: which words land where, the final status and
  // how many cycles after the start edge that status appears.
  task automatic model_build();
    int         n;
    logic [7:0] sum;
    logic [31:0] w;
    exp_q.delete();
    n   = int'(stim_q[0]);
    sum = 8'd0;
    if (n > CAP_WORDS) begin
      exp_done = 1'b0;
      exp_err  = 1'b1;
      exp_wcnt = 0;
      exp_lat  = 1;
      return;
    end
    for (int i = 0; i < n; i++) begin
      w = {stim_q[1+4*i], stim_q[2+4*i], stim_q[3+4*i], stim_q[4+4*i]};
      exp_q.push_back({ADDR_W'(4 * i), w});
      for (int k = 1; k <= 4; k++) sum = sum + stim_q[k+4*i];
    end
    exp_wcnt = n;
    exp_lat  = 1 + 5 * n + CS;
    exp_done = 1'b1;
    exp_err  = 1'b0;
`ifdef LOADER_CHECKSUM_EN
    if (stim_q[1+4*n] != sum) begin
      exp_done = 1'b0;
      exp_err  = 1'b1;
    end
`endif
  endtask

  // Random image of n words; oversize images carry only their header.
  task automatic make_image(input int n);
    logic [7:0] sum, b;
    stim_q.delete();
    stim_q.push_back(8'(n));
    sum = 8'd0;
    if (n > CAP_WORDS) return;
    for (int i = 0; i < 4 * n; i++) begin
      b = 8'($urandom);
      stim_q.push_back(b);
      sum = sum + b;
    end
`ifdef LOADER_CHECKSUM_EN
    stim_q.push_back(cs_good ? sum : (sum ^ 8'(1 << $urandom_range(0, 7))));
`endif
  endtask

  // The two-word program used by the directed tests.
  task automatic make_fixed(input logic [7:0] csum);
    stim_q.delete();
    stim_q = '{8'h02, 8'h00, 8'h00, 8'h08, 8'h20, 8'h00, 8'h01, 8'h10, 8'h21};
`ifdef LOADER_CHECKSUM_EN
    stim_q.push_back(csum);
`else
    if (csum != 8'h5A) stim_q.push_back(csum);
`endif
  endtask

  // ---------------- driver tasks ----------------
  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic send_byte(input logic [7:0] b, input bit gap);
    int t;
    if (gap) begin
      bus.in_valid = 1'b0;
      @(negedge CLK);
    end
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    t = 0;
    while (!bus.in_ready && t < 50) begin
      @(negedge CLK);
      t++;
    end
    if (t >= 50) check("ready_timeout", 64'(t), 64'd0);
    @(negedge CLK);
  endtask

  task automatic pulse_start();
    @(negedge CLK);
    start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
  endtask

  // gap_mode: 0 continuous, 1 gap before every byte, 2 random gaps.
  task automatic run_load(input string name, input int gap_mode, input bit poke);
    int          t;
    int unsigned c0;
    int          nexp;
    bit          g;
    obs_q.delete();
    model_build();
    pulse_start();
    c0 = cyc;
    check({name, "_start_cpu_rst"}, 64'(cpu_rst_n), 64'd0);
    check({name, "_start_busy"}, 64'(busy), 64'd1);
    for (int k = 0; k < stim_q.size(); k++) begin
      g = (gap_mode == 1) || (gap_mode == 2 && $urandom_range(0, 2) == 0);
      start = poke && (k == 2);
      send_byte(stim_q[k], g);
    end
    start = 1'b0;
    bus.in_valid = 1'b0;
    t = 0;
    while (!(done || err) && t < 100) begin
      @(negedge CLK);
      t++;
    end
    check({name, "_finish_timeout"}, 64'(t >= 100), 64'd0);
    if (gap_mode == 0) check({name, "_latency"}, 64'(cyc - c0), 64'(exp_lat));
    repeat (2) @(negedge CLK);
    check({name, "_done"}, 64'(done), 64'(exp_done));
    check({name, "_err"}, 64'(err), 64'(exp_err));
    check({name, "_cpu_rst_n"}, 64'(cpu_rst_n), 64'(exp_done));
    check({name, "_busy"}, 64'(busy), 64'd0);
    check({name, "_in_ready"}, 64'(bus.in_ready), 64'd0);
    check({name, "_word_cnt"}, 64'(word_cnt), 64'(exp_wcnt));
    check({name, "_n_writes"}, 64'(obs_q.size()), 64'(exp_q.size()));
    nexp = exp_q.size();
    for (int i = 0; i < nexp && i < obs_q.size(); i++)
      check({name, "_write"}, 64'(obs_q[i]), 64'(exp_q[i]));
  endtask

  task automatic check_reset_vals(input string name);
    check({name, "_in_ready"}, 64'(bus.in_ready), 64'd0);
    check({name, "_mem_we"}, 64'(bus.mem_we), 64'd0);
    check({name, "_mem_addr"}, 64'(bus.mem_addr), 64'd0);
    check({name, "_mem_wdata"}, 64'(bus.mem_wdata), 64'd0);
    check({name, "_cpu_rst_n"}, 64'(cpu_rst_n), 64'd0);
    check({name, "_busy"}, 64'(busy), 64'd0);
    check({name, "_done"}, 64'(done), 64'd0);
    check({name, "_err"}, 64'(err), 64'd0);
    check({name, "_word_cnt"}, 64'(word_cnt), 64'd0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    cs_good      = 1'b1;

    // Reset and idle behaviour
    repeat (3) @(negedge CLK);
    check_reset_vals("reset");
    Reset_n = 1'b1;
    @(negedge CLK);
    bus.in_valid = 1'b1;
    bus.in_data  = 8'hAA;
    repeat (5) @(negedge CLK);
    check("idle_in_ready", 64'(bus.in_ready), 64'd0);
    check("idle_busy", 64'(busy), 64'd0);
    bus.in_valid = 1'b0;

    // Directed two-word program, continuous, with a start poke mid-load
    make_fixed(8'h5A);
    run_load("fixed", 0, 1'b1);
    check("fixed_w0", 64'(obs_q.size() > 0 ? obs_q[0] : '0), 64'({8'h00, 32'h0000_0820}));
    check("fixed_w1", 64'(obs_q.size() > 1 ? obs_q[1] : '0), 64'({8'h04, 32'h0001_1021}));

    // Same program from a source that gaps every other cycle
    make_fixed(8'h5A);
    run_load("gapped", 1, 1'b0);

    // Oversize header and the largest legal image
    make_image(CAP_WORDS + 1);
    run_load("oversize", 0, 1'b0);
    make_image(CAP_WORDS);
    run_load("max", 0, 1'b0);
    check("max_last_addr", 64'(obs_q.size() > 0 ? obs_q[obs_q.size()-1][W-1:32] : '0),
          64'((1 << ADDR_W) - 4));

    // Checksum mismatch then recovery
`ifdef LOADER_CHECKSUM_EN
    make_fixed(8'h5B);
    run_load("bad_csum", 0, 1'b0);
    make_fixed(8'h5A);
    run_load("good_csum", 0, 1'b0);
`endif

    // Empty image
    make_image(0);
    run_load("empty", 0, 1'b0);

    // Reset after six payload bytes aborts the load
    make_fixed(8'h5A);
    obs_q.delete();
    pulse_start();
    for (int k = 0; k < 7; k++) send_byte(stim_q[k], 1'b0);
    Reset_n = 1'b0;
    #1;
    check_reset_vals("abort");
    check("abort_n_writes", 64'(obs_q.size()), 64'd1);
    check("abort_w0", 64'(obs_q.size() > 0 ? obs_q[0] : '0), 64'({8'h00, 32'h0000_0820}));
    bus.in_valid = 1'b0;
    @(negedge CLK);
    Reset_n = 1'b1;
    @(negedge CLK);
    check("abort_cpu_rst_n", 64'(cpu_rst_n), 64'd0);
    make_fixed(8'h5A);
    run_load("after_abort", 0, 1'b0);

    // Randomized images, sizes, checksums and source gaps
    for (int it = 0; it < 20; it++) begin
      cs_good = ($urandom_range(0, 3) != 0);
      make_image($urandom_range(0, CAP_WORDS + 6));
      run_load("rand", $urandom_range(0, 2), 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global time limit
  initial begin
    #2_000_000;
    n_checks++;
    n_fail++;
    $display("FAIL global_timeout: got time %0t expected completion", $time);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time program loader for the single-cycle CPU: accepts a byte stream over a valid/ready handshake, assembles big-endian 32-bit instruction words and writes them word-by-word into the byte-addressed instruction memory starting at address 0. It is the writer side of the instruction memory, which the CPU only reads. It holds the CPU in reset until a complete, valid image has been written.

## Interface
- ADDR_W, 8, instruction-memory byte-address width; capacity is 2^ADDR_W bytes (64 words at default)
- CLK  in  1  clock, all state updates on rising edge
- Reset_n  in  1  asynchronous, active-low reset
- start  in  1  single-cycle pulse; begins a load from IDLE, DONE or ERR
- in_valid  in  1  source has a byte on in_data
- in_data  in  8  stream byte
- in_ready  out  1  loader accepts in_data this cycle
- mem_we  out  1  one-cycle word write strobe
- mem_addr  out  ADDR_W  byte address of the word (always multiple of 4)
- mem_wdata  out  32  word; mem_wdata[31:24] goes to mem_addr, [7:0] to mem_addr+3
- cpu_rst_n  out  1  CPU reset, low except in DONE
- busy  out  1  high in HDR, DATA, WRITE, CSUM
- done  out  1  high in DONE
- err  out  1  high in ERR
- word_cnt  out  8  words written in the current load

## Operation
- Stream format: header byte N (word count), then 4·N payload bytes, most-significant byte of each word first; then one checksum byte when the checksum is compiled in.
- States: IDLE, HDR, DATA, WRITE, CSUM, DONE, ERR.
- IDLE: in_ready=0. On start -> HDR; word_cnt, byte index, address, and checksum accumulator cleared.
- HDR: in_ready=1. On a byte: if 4·N > 2^ADDR_W -> ERR; N=0 -> CSUM (checksum compiled in) or DONE; otherwise latch N -> DATA.
- DATA: in_ready=1. Each accepted byte shifts into the word register (bits shift left by 8) and is added to the checksum (mod 256). The 4th byte -> WRITE.
- WRITE: in_ready=0, mem_we=1 for exactly one cycle, mem_addr=4·word_cnt, mem_wdata=assembled word. Then word_cnt+1. If word_cnt+1 == N -> CSUM or DONE; else -> DATA.
- CSUM: in_ready=1. On a byte: equal to accumulator -> DONE, else -> ERR.
- DONE: cpu_rst_n=1, done=1. ERR: err=1, cpu_rst_n=0. Both remain until start or reset.
- start is ignored while busy. start in DONE/ERR drops cpu_rst_n the next cycle and reloads.
- Bytes are never lost: in_valid with in_ready=0 is not consumed, and the source must hold it.

## Timing
- Reset (async assert, sync release): state=IDLE, in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, cpu_rst_n=0, busy=0, done=0, err=0, word_cnt=0.
- A byte is accepted on a rising edge where in_valid and in_ready are both high. in_ready is a registered state decode, not combinational on in_valid.
- Throughput: 5 cycles per word with a continuous source (4 accept cycles and 1 WRITE). From start, a load with N words completes in 1 + 1 + 5N cycles, plus 1 with the checksum.
- mem_addr and mem_wdata are stable only during mem_we. They hold their last value otherwise.
- A reset in mid-load aborts the load immediately. Words already written remain in memory, and cpu_rst_n stays low.
- The largest image, 4·N == 2^ADDR_W, is legal. The last address is 2^ADDR_W−4, with no wrap.

## Configuration
- LOADER_CHECKSUM_EN defined: a CSUM state and a trailing checksum byte are required. The checksum is the 8-bit sum of payload bytes only (the header is excluded), so N=0 expects 0x00. A mismatch -> ERR.
- Not defined: no CSUM state, the accumulator is removed, and the last WRITE (or N=0 header) goes directly to DONE; err then arises only from oversize N.

## Test plan
- Reset: after Reset_n low, all outputs at reset values; in_valid=1 with no start -> in_ready stays 0.
- Load N=2 with bytes 00 00 08 20, 00 01 10 21 (and checksum 0x5A when enabled) -> writes 0x00000820 @0 and 0x00011021 @4. Then done=1, cpu_rst_n=1, word_cnt=2.
- Gapped source: in_valid toggles every other cycle during the same image -> identical writes, each mem_we exactly 1 cycle, no extra or dropped bytes.
- Oversize: header 65 with ADDR_W=8 -> ERR the next cycle, no mem_we, cpu_rst_n=0. Header 64 -> 64 writes, last at address 252.
- Checksum (enabled): the same image with checksum 0x5B -> err=1, cpu_rst_n=0. Then start and a correct image -> done=1.
- Abort: Reset_n low after 6 payload bytes -> IDLE immediately with outputs at reset values. Start, then a full image -> correct completion.
